// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit seven-segment scan scheduler with tear-free bulk buffer load
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  digit_en,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        digit_on,
  output logic        frame_done
);

  typedef enum logic {S_IDLE, S_PENDING} load_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       num_q, num_d;
  logic             digit_on_q, digit_on_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       disp_q [8];
  logic [3:0]       disp_d [8];
  logic [31:0]      shadow_q, shadow_d;
  load_state_e      state_q, state_d;
  logic             tick, wrap, commit;

  // Outputs are registered against sel_d so num/sel/digit_on switch on the same edge.
  always_comb begin
    tick         = scan_en && (cnt_q == CNT_LAST);
    wrap         = tick && (sel_q == 3'd7);
    cnt_d        = cnt_q;
    if (scan_en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    sel_d        = tick ? sel_q + 3'd1 : sel_q;
    num_d        = disp_q[sel_d];
    digit_on_d   = digit_en[sel_d];
    frame_done_d = wrap;
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    commit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          shadow_d = load_data;
          state_d  = S_PENDING;
        end
      end
      S_PENDING: begin
        if (wrap) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A direct write lands on top of a same-cycle commit.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      disp_d[i] = commit ? shadow_q[4*i +: 4] : disp_q[i];
    end
    if (wr_en) disp_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sel_q        <= '0;
      num_q        <= '0;
      digit_on_q   <= 1'b0;
      frame_done_q <= 1'b0;
      shadow_q     <= '0;
      state_q      <= S_IDLE;
      for (int i = 0; i < 8; i++) disp_q[i] <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      num_q        <= num_d;
      digit_on_q   <= digit_on_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      state_q      <= state_d;
      for (int i = 0; i < 8; i++) disp_q[i] <= disp_d[i];
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign num        = num_q;
  assign sel        = sel_q;
  assign digit_on   = digit_on_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl at REFRESH_DIV=4
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  digit_en;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        digit_on;
  logic        frame_done;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .digit_en(digit_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .num(num), .sel(sel), .digit_on(digit_on), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int fd_seen = 0;

  // reference model state
  int          m_cnt;
  logic [2:0]  m_sel;
  logic [3:0]  m_buf [8];
  logic [31:0] m_shadow;
  bit          m_pend;

  logic [9:0]  exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sel = 3'd0; m_shadow = '0; m_pend = 1'b0;
    for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
  endtask

  // Predict the outputs of the coming edge, queue them, then compare after the edge.
  task automatic cycle();
    bit         tick, wrap;
    logic [2:0] nsel;
    logic [3:0] e_num;
    logic       e_don;
    logic [9:0] e, g;
    tick  = scan_en && (m_cnt == DIV - 1);
    nsel  = tick ? m_sel + 3'd1 : m_sel;
    wrap  = tick && (m_sel == 3'd7);
    e_num = m_buf[nsel];
    e_don = digit_en[nsel];
    if (m_pend && wrap) begin
      for (int i = 0; i < 8; i++) m_buf[i] = m_shadow[4*i +: 4];
      m_pend = 1'b0;
    end else if (!m_pend && load_valid) begin
      m_shadow = load_data;
      m_pend   = 1'b1;
    end
    if (wr_en) m_buf[wr_addr] = wr_data;
    if (tick) m_cnt = 0;
    else if (scan_en) m_cnt = m_cnt + 1;
    m_sel = nsel;
    exp_q.push_back({nsel, e_num, e_don, wrap, ~m_pend});
    @(posedge clk);
    #1;
    g = {sel, num, digit_on, frame_done, load_ready};
    e = exp_q.pop_front();
    if (frame_done) fd_seen++;
    chk("sel",        32'(g[9:7]), 32'(e[9:7]));
    chk("num",        32'(g[6:3]), 32'(e[6:3]));
    chk("digit_on",   32'(g[2]),   32'(e[2]));
    chk("frame_done", 32'(g[1]),   32'(e[1]));
    chk("load_ready", 32'(g[0]),   32'(e[0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_sel(input logic [2:0] s);
    int n = 0;
    while (m_sel != s && n < 100) begin cycle(); n++; end
    if (m_sel != s) chk("wait_sel", 32'(m_sel), 32'(s));
  endtask

  // Stops just before the cycle whose edge wraps sel 7->0.
  task automatic run_until_wrap_cycle();
    int n = 0;
    while (!(m_sel == 3'd7 && m_cnt == DIV - 1) && n < 100) begin cycle(); n++; end
    if (!(m_sel == 3'd7 && m_cnt == DIV - 1)) chk("wait_wrap", 32'(n), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b0; digit_en = 8'hFF;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_valid = 1'b0; load_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_num", 32'(num), 0);
    chk("rst_don", 32'(digit_on), 0);
    chk("rst_fd",  32'(frame_done), 0);
    chk("rst_rdy", 32'(load_ready), 1);
    rst_n = 1'b1;

    // free-running scan of an all-zero buffer
    scan_en = 1'b1;
    fd_seen = 0;
    run(32);
    chk("fd_count", 32'(fd_seen), 1);
    run(8);

    // direct write to digit 3 while digit 2 shows
    run_until_sel(3'd2);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
    cycle();
    wr_en = 1'b0;
    run_until_sel(3'd3);
    chk("wr_d3", 32'(num), 32'hA);
    run(8);

    // bulk load accepted at sel=2, committed at the next wrap
    run_until_sel(3'd2);
    load_valid = 1'b1; load_data = 32'h7654_3210;
    cycle();
    load_valid = 1'b0;
    chk("ld_busy", 32'(load_ready), 0);
    run_until_wrap_cycle();
    cycle();
    chk("ld_done", 32'(load_ready), 1);
    run(36);

    // direct write collides with commit of an all-F shadow
    load_valid = 1'b1; load_data = 32'hFFFF_FFFF;
    cycle();
    load_valid = 1'b0;
    run_until_wrap_cycle();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h5;
    cycle();
    wr_en = 1'b0;
    cycle();
    chk("coll_d0", 32'(num), 32'h5);
    run(32);

    // freeze on digit 5 with digit 5 masked off
    digit_en = 8'hDF;
    run_until_sel(3'd5);
    cycle();
    scan_en = 1'b0;
    fd_seen = 0;
    run(20);
    chk("frz_sel", 32'(sel), 5);
    chk("frz_don", 32'(digit_on), 0);
    chk("frz_fd",  32'(fd_seen), 0);
    scan_en = 1'b1;
    run(12);
    digit_en = 8'hFF;

    // async reset while a load is pending at sel=6
    load_valid = 1'b1; load_data = 32'h1234_5678;
    cycle();
    load_valid = 1'b0;
    run_until_sel(3'd6);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 0);
    chk("arst_num", 32'(num), 0);
    chk("arst_don", 32'(digit_on), 0);
    chk("arst_rdy", 32'(load_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(72);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
